// File: rtl/node_control_mc.sv
// AXI-lite control slave for a processing-node array: per-node offsets, activation,
// saturating run counters, a 64-bit global cycle counter and a finish-event FIFO.
module node_control_mc #(
  parameter int NUM_NODES = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int EVT_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_W-1:0]       s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_W-1:0]       s_axi_wdata,
  input  logic [3:0]              s_axi_wstrb,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_W-1:0]       s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_W-1:0]       s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic [NUM_NODES-1:0]    node_active,
  output logic [NUM_NODES*32-1:0] node_offset,
  output logic [7:0]              leds_status,
  output logic [7:0]              triggers,
  output logic                    evt_irq
);

  localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam int PTR_W  = $clog2(EVT_DEPTH);
  localparam int ACT_W  = (NUM_NODES < 32) ? NUM_NODES : 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WRESP, RRESP} state_t;
  state_t state, state_nxt;

  logic [11:2]       addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [1:0]        bresp_q, rresp_q;
  logic              awready_q, wready_q, arready_q;

  logic [31:0]          offset  [NUM_NODES];
  logic [31:0]          run_cnt [NUM_NODES];
  logic [NUM_NODES-1:0] active;
  logic [6:0]           num_active;
  logic [63:0]          global_cnt;
  logic [31:0]          hi_snap;
  logic [7:0]           leds_q, trig_q;

  logic [31:0]   evt_mem [EVT_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, evt_level;
  logic          evt_ovf, evt_empty, evt_full, evt_push;
  logic [31:0]   evt_word;

  logic              unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                       s_axi_awaddr[ADDR_W-1:12], s_axi_awaddr[1:0],
                       s_axi_araddr[ADDR_W-1:12], s_axi_araddr[1:0]};

  // Address decode of the latched transaction.
  logic [NODE_W-1:0] node_sel;
  logic node_ok, in_off, in_ctrl, in_cnt, rd_err, wr_err, do_wr, do_rd;
  logic [31:0] rd_val;

  assign node_sel = addr_q[NODE_W+1:2];
  assign node_ok  = ({26'd0, addr_q[7:2]} < 32'(NUM_NODES));
  assign in_off   = (addr_q[11:8] == 4'h0);
  assign in_ctrl  = (addr_q[11:8] == 4'h1);
  assign in_cnt   = (addr_q[11:8] == 4'h2);
  assign do_wr    = (state == WRITE) && !wr_err;
  assign do_rd    = (state == READ) && !rd_err;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    rd_err = 1'b1;
    wr_err = 1'b1;
    rd_val = '0;
    if (in_off && node_ok) begin
      rd_err = 1'b0;
      wr_err = 1'b0;
      rd_val = offset[node_sel];
    end else if (in_cnt && node_ok) begin
      rd_err = 1'b0;
      rd_val = run_cnt[node_sel];
    end else if (in_ctrl) begin
      case (addr_q[7:2])
        6'h00: begin rd_err = 1'b0; rd_val[ACT_W-1:0] = active[ACT_W-1:0]; end
        6'h01: begin rd_err = 1'b0; rd_val = 32'(num_active); end
        6'h02: begin rd_err = 1'b0; rd_val = global_cnt[31:0]; end
        6'h03: begin rd_err = 1'b0; rd_val = hi_snap; end
        6'h04: wr_err = 1'b0;
        6'h05: begin rd_err = 1'b0; wr_err = 1'b0; rd_val = {24'd0, leds_q}; end
        6'h06: begin rd_err = 1'b0; wr_err = 1'b0; rd_val = {24'd0, trig_q}; end
        6'h07: begin rd_err = 1'b0; rd_val = {evt_ovf, 15'd0, 16'(evt_level)}; end
        6'h08: begin
          rd_err = 1'b0;
          rd_val = evt_empty ? 32'hFFFF_FFFF : evt_mem[rd_ptr[PTR_W-1:0]];
        end
        default: ;
      endcase
    end
  end

  logic wr_off, wr_start, wr_glb_rst, wr_leds, wr_trig, rd_glb_lo, rd_status, rd_pop;
  assign wr_off     = do_wr && in_off;
  assign wr_start   = (wdata_q[31:0] != 32'd0);
  assign wr_glb_rst = do_wr && in_ctrl && (addr_q[7:2] == 6'h04);
  assign wr_leds    = do_wr && in_ctrl && (addr_q[7:2] == 6'h05);
  assign wr_trig    = do_wr && in_ctrl && (addr_q[7:2] == 6'h06);
  assign rd_glb_lo  = do_rd && in_ctrl && (addr_q[7:2] == 6'h02);
  assign rd_status  = do_rd && in_ctrl && (addr_q[7:2] == 6'h07);
  assign rd_pop     = do_rd && in_ctrl && (addr_q[7:2] == 6'h08);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_axi_awvalid && s_axi_wvalid) state_nxt = WRITE;
        else if (s_axi_arvalid)            state_nxt = READ;
      end
      WRITE: state_nxt = WRESP;
      READ:  state_nxt = RRESP;
      WRESP: if (s_axi_bready) state_nxt = IDLE;
      RRESP: if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      awready_q <= (state == IDLE) && s_axi_awvalid && s_axi_wvalid;
      wready_q  <= (state == IDLE) && s_axi_awvalid && s_axi_wvalid;
      arready_q <= (state == IDLE) && !(s_axi_awvalid && s_axi_wvalid) && s_axi_arvalid;
      if (state == IDLE) begin
        if (s_axi_awvalid && s_axi_wvalid) begin
          addr_q  <= s_axi_awaddr[11:2];
          wdata_q <= s_axi_wdata;
        end else if (s_axi_arvalid) begin
          addr_q <= s_axi_araddr[11:2];
        end
      end
      if (state == WRITE) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (state == READ) begin
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
        rdata_q <= rd_err ? '0 : DATA_W'(rd_val);
      end
    end
  end

  // A restart clears the counter even when the node is already counting.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int n = 0; n < NUM_NODES; n++) begin
        offset[n]  <= '0;
        run_cnt[n] <= '0;
      end
      active     <= '0;
      num_active <= '0;
    end else begin
      for (int n = 0; n < NUM_NODES; n++) begin
        if (wr_off && wr_start && (node_sel == NODE_W'(n)))
          run_cnt[n] <= '0;
        else if (active[n] && (run_cnt[n] != 32'hFFFF_FFFF))
          run_cnt[n] <= run_cnt[n] + 32'd1;
      end
      if (wr_off) begin
        offset[node_sel] <= wdata_q[31:0];
        active[node_sel] <= wr_start;
        if (wr_start && !active[node_sel])      num_active <= num_active + 7'd1;
        else if (!wr_start && active[node_sel]) num_active <= num_active - 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      global_cnt <= '0;
      hi_snap    <= '0;
      leds_q     <= '0;
      trig_q     <= '0;
    end else begin
      global_cnt <= wr_glb_rst ? 64'd0 : global_cnt + 64'd1;
      if (rd_glb_lo) hi_snap <= global_cnt[63:32];
      if (wr_leds)   leds_q  <= wdata_q[7:0];
      if (wr_trig)   trig_q  <= wdata_q[7:0];
    end
  end

  assign evt_level = wr_ptr - rd_ptr;
  assign evt_empty = (evt_level == '0);
  assign evt_full  = (evt_level == (PTR_W+1)'(EVT_DEPTH));
  assign evt_push  = wr_off && !wr_start && active[node_sel];
  assign evt_word  = {8'(node_sel),
                      (run_cnt[node_sel] > 32'h00FF_FFFF) ? 24'hFF_FFFF : run_cnt[node_sel][23:0]};

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      evt_ovf <= 1'b0;
    end else begin
      if (rd_status) evt_ovf <= 1'b0;
      if (evt_push) begin
        if (evt_full) evt_ovf <= 1'b1;
        else          wr_ptr  <= wr_ptr + 1'b1;
      end
      if (rd_pop && !evt_empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage arrays are not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (evt_push && !evt_full) evt_mem[wr_ptr[PTR_W-1:0]] <= evt_word;
  end

  always_comb begin
    node_offset = '0;
    for (int n = 0; n < NUM_NODES; n++) node_offset[32*n +: 32] = offset[n];
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = (state == WRESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (state == RRESP);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign node_active   = active;
  assign leds_status   = leds_q;
  assign triggers      = trig_q;
  assign evt_irq       = !evt_empty;

endmodule

// File: tb/tb_node_control_mc.sv
// Self-checking bench for node_control_mc: register-map vector table plus
// hand-written sequences for counters, event FIFO and handshake/reset corners.
module tb_node_control_mc;

  localparam int TMO = 32;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic        clk = 1'b0;
  logic        res_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [7:0]  node_active, leds_status, triggers;
  logic [255:0] node_offset;
  logic        evt_irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  node_control_mc dut (
    .clk(clk), .res_n(res_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awprot(awprot),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr), .s_axi_arprot(arprot),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .node_active(node_active), .node_offset(node_offset), .leds_status(leds_status),
    .triggers(triggers), .evt_irq(evt_irq)
  );

  typedef struct { logic [1:0] resp; logic [31:0] data; bit chk_data; } exp_t;
  exp_t sb_q[$];

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; logic [1:0] resp; logic [31:0] rdata; } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act, input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if (!(act >= lo && act <= hi)) begin
      failures++;
      $display("FAIL %s: got %h, want %h..%h", name, act, lo, hi);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp, output bit ok);
    bit got;
    ok = 1'b0; resp = 2'b11; got = 1'b0;
    @(negedge clk);
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (awready && wready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (got) begin
      bready = 1'b1;
      for (int i = 0; i < TMO; i++) begin
        @(negedge clk);
        if (bvalid) begin resp = bresp; ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp, output bit ok);
    bit got;
    ok = 1'b0; resp = 2'b11; data = 32'hDEAD_BEEF; got = 1'b0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (arready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (got) begin
      rready = 1'b1;
      for (int i = 0; i < TMO; i++) begin
        @(negedge clk);
        if (rvalid) begin resp = rresp; data = rdata; ok = 1'b1; break; end
      end
      @(posedge clk); #1;
      rready = 1'b0;
    end
  endtask

  task automatic wr_chk(input string name, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
    exp_t e;
    logic [1:0] r;
    bit ok;
    sb_q.push_back('{resp: exp_resp, data: 32'd0, chk_data: 1'b0});
    axi_write(addr, data, r, ok);
    e = sb_q.pop_front();
    check({name, "_done"}, 64'(ok), 64'd1);
    if (ok) check({name, "_bresp"}, 64'(r), 64'(e.resp));
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    exp_t e;
    logic [1:0] r;
    logic [31:0] d;
    bit ok;
    sb_q.push_back('{resp: exp_resp, data: exp_data, chk_data: 1'b1});
    axi_read(addr, d, r, ok);
    e = sb_q.pop_front();
    check({name, "_done"}, 64'(ok), 64'd1);
    if (ok) begin
      check({name, "_rresp"}, 64'(r), 64'(e.resp));
      if (e.chk_data) check({name, "_rdata"}, 64'(d), 64'(e.data));
    end
  endtask

  task automatic rd_val(input string name, input logic [31:0] addr, output logic [31:0] d);
    logic [1:0] r;
    bit ok;
    axi_read(addr, d, r, ok);
    check({name, "_done"}, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    res_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    repeat (2) @(negedge clk);
    res_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_hs"}, 64'({awready, wready, arready, bvalid, rvalid, evt_irq}), 64'd0);
    check({name, "_regs"}, 64'({node_active, leds_status, triggers}), 64'd0);
    check({name, "_offsets"}, 64'(|node_offset), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    bit ok, got, saw_ar, stable, seen, any_bad;

    res_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; awprot = '0; arprot = '0; wstrb = 4'hF;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_during");
    res_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_after");

    // Register map vectors: decode errors, RO/WO protection, RW registers.
    vecs.push_back('{1'b1, 32'h020, 32'h0000_DEAD, SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h020, 32'h0,         SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h300, 32'h0,         SLVERR, 32'h0});
    vecs.push_back('{1'b1, 32'h300, 32'h1,         SLVERR, 32'h0});
    vecs.push_back('{1'b1, 32'h100, 32'hFF,        SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h100, 32'h0,         OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h110, 32'h0,         SLVERR, 32'h0});
    vecs.push_back('{1'b1, 32'h104, 32'h5,         SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h104, 32'h0,         OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h120, 32'h0,         OKAY,   32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 32'h11C, 32'h0,         OKAY,   32'h0});
    vecs.push_back('{1'b1, 32'h114, 32'h1A5,       OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h114, 32'h0,         OKAY,   32'hA5});
    vecs.push_back('{1'b1, 32'h118, 32'h3C,        OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h118, 32'h0,         OKAY,   32'h3C});
    vecs.push_back('{1'b1, 32'h01C, 32'h1234,      OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h01C, 32'h0,         OKAY,   32'h1234});
    vecs.push_back('{1'b0, 32'h100, 32'h0,         OKAY,   32'h80});
    vecs.push_back('{1'b0, 32'h104, 32'h0,         OKAY,   32'h1});
    vecs.push_back('{1'b0, 32'h220, 32'h0,         SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h204, 32'h0,         OKAY,   32'h0});
    vecs.push_back('{1'b1, 32'h204, 32'h7,         SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h1000_0114, 32'h0,   OKAY,   32'hA5});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) wr_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].resp);
      else            rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rdata, vecs[i].resp);
    end
    @(negedge clk);
    check("vec_leds_pin", 64'(leds_status), 64'hA5);
    check("vec_trig_pin", 64'(triggers), 64'h3C);
    check("vec_active_pin", 64'(node_active), 64'h80);
    check("vec_offset7_pin", 64'(node_offset[7*32 +: 32]), 64'h1234);

    // Start node 2, run ~100 cycles, stop; event logged with node id and count.
    do_reset();
    wr_chk("t1_start", 32'h008, 32'h0000_4000, OKAY);
    @(negedge clk);
    check("t1_active_on", 64'(node_active), 64'h04);
    repeat (99) @(posedge clk);
    wr_chk("t1_stop", 32'h008, 32'h0, OKAY);
    @(negedge clk);
    check("t1_active_off", 64'(node_active), 64'h00);
    check("t1_irq_set", 64'(evt_irq), 64'd1);
    rd_chk("t1_num_active", 32'h104, 32'h0, OKAY);
    rd_chk("t1_status", 32'h11C, 32'h1, OKAY);
    rd_val("t1_pop", 32'h120, d);
    check("t1_pop_node", 64'(d[31:24]), 64'h02);
    check_range("t1_pop_count", {8'd0, d[23:0]}, 32'd97, 32'd103);
    @(negedge clk);
    check("t1_irq_clear", 64'(evt_irq), 64'd0);

    // Restart of an already active node keeps NUM_ACTIVE and clears its counter.
    do_reset();
    wr_chk("t2_start_a", 32'h000, 32'h1000, OKAY);
    repeat (50) @(posedge clk);
    wr_chk("t2_start_b", 32'h000, 32'h1000, OKAY);
    rd_chk("t2_num_active", 32'h104, 32'h1, OKAY);
    rd_val("t2_count", 32'h200, d);
    check_range("t2_count_restart", d, 32'd0, 32'd8);
    rd_chk("t2_offset", 32'h000, 32'h1000, OKAY);

    // Global counter: high-word snapshot taken on the low-word read.
    do_reset();
    @(negedge clk);
    force dut.global_cnt = 64'h0000_0000_FFFF_FFC0;
    @(negedge clk);
    release dut.global_cnt;
    rd_val("t3_lo_pre", 32'h108, d);
    check_range("t3_lo_pre_val", d, 32'hFFFF_FFC0, 32'hFFFF_FFFF);
    repeat (100) @(posedge clk);
    rd_chk("t3_hi_snap_old", 32'h10C, 32'h0, OKAY);
    rd_val("t3_lo_post", 32'h108, d);
    check_range("t3_lo_post_val", d, 32'h0, 32'h100);
    rd_chk("t3_hi_snap_new", 32'h10C, 32'h1, OKAY);
    wr_chk("t3_glb_reset", 32'h110, 32'h1, OKAY);
    rd_val("t3_lo_cleared", 32'h108, d);
    check_range("t3_lo_cleared_val", d, 32'd1, 32'd8);
    rd_chk("t3_hi_cleared", 32'h10C, 32'h0, OKAY);

    // 17 finish events into a 16-deep FIFO: overflow sticky until status read.
    do_reset();
    any_bad = 1'b0;
    for (int i = 0; i < 17; i++) begin
      axi_write(32'h004, 32'h100, r, ok);
      if (!ok || r != OKAY) any_bad = 1'b1;
      axi_write(32'h004, 32'h0, r, ok);
      if (!ok || r != OKAY) any_bad = 1'b1;
    end
    check("t4_writes_bad", 64'(any_bad), 64'd0);
    rd_chk("t4_status_ovf", 32'h11C, 32'h8000_0010, OKAY);
    rd_chk("t4_status_clr", 32'h11C, 32'h0000_0010, OKAY);
    for (int i = 0; i < 16; i++) begin
      rd_val($sformatf("t4_pop%0d", i), 32'h120, d);
      check($sformatf("t4_pop%0d_node", i), 64'(d[31:24]), 64'h01);
    end
    rd_chk("t4_pop_empty", 32'h120, 32'hFFFF_FFFF, OKAY);
    rd_chk("t4_status_empty", 32'h11C, 32'h0, OKAY);
    @(negedge clk);
    check("t4_irq_low", 64'(evt_irq), 64'd0);

    // Simultaneous write and read, stalled response, then reset mid-transaction.
    do_reset();
    @(negedge clk);
    awaddr = 32'h114; wdata = 32'h5A; araddr = 32'h118;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    got = 1'b0; saw_ar = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (arready) saw_ar = 1'b1;
      if (awready && wready) begin got = 1'b1; break; end
    end
    check("t6_write_first", 64'(got), 64'd1);
    check("t6_read_held", 64'(saw_ar), 64'd0);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bvalid) begin got = 1'b1; break; end
    end
    check("t6_bvalid", 64'(got), 64'd1);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!(bvalid === 1'b1 && bresp === OKAY && arready === 1'b0 && rvalid === 1'b0)) stable = 1'b0;
    end
    check("t6_b_stable", 64'(stable), 64'd1);
    check("t6_leds_written", 64'(leds_status), 64'h5A);
    res_n = 1'b0;
    arvalid = 1'b0;
    #1;
    check_idle_outputs("t6_in_reset");
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    bready = 1'b1; rready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bvalid || rvalid) seen = 1'b1;
    end
    bready = 1'b0; rready = 1'b0;
    check("t6_no_response", 64'(seen), 64'd0);
    rd_chk("t6_idle_read", 32'h114, 32'h0, OKAY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
